iter_muldiv_unit: RTL and testbench
===================================

# iter_muldiv_unit

Parametrised, iterative multiply/divide execute unit for the TinyRV pipeline. It replaces the single-cycle combinational multiplier in stage X with a variable-latency unit that has a val/rdy handshake, a configurable operand width and four operation modes. It computes one bit per cycle using shift-add and restoring division. Control stalls X while the unit is busy and consumes the result when `ostream_val` is high.

## Interface
- `WIDTH`, default 32: operand and result width. Must be even and ≥ 4.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `istream_val`  in  1  request valid.
- `istream_rdy`  out  1  unit can accept a request.
- `istream_fn`  in  2  operation: 0 = MUL (low half), 1 = MULHU (high half, unsigned), 2 = DIVU, 3 = REMU.
- `istream_a`  in  WIDTH  operand A (multiplicand or dividend).
- `istream_b`  in  WIDTH  operand B (multiplier or divisor).
- `ostream_val`  out  1  result valid.
- `ostream_rdy`  in  1  consumer accepts the result.
- `ostream_result`  out  WIDTH  result.
- `busy`  out  1  high in CALC or DONE.

## Operation
- **Reset values:** state = IDLE, `istream_rdy` = 0 while `rst` is high, `ostream_val` = 0, `ostream_result` = 0, `busy` = 0, counter = 0.
- **FSM:** IDLE → CALC → DONE → IDLE.
- **IDLE:**
  - `istream_rdy` = 1 (when `rst` is low).
  - On `istream_val` && `istream_rdy`, latch fn, a and b; clear the accumulators; counter ← 0; go to CALC.
- **CALC:**
  - Perform one iteration per cycle.
  - After WIDTH iterations (counter == WIDTH−1 on the final cycle), go to DONE.
  - `istream_val` and all operand inputs are ignored.
- **MUL / MULHU:**
  - 2·WIDTH product register, shift-add, LSB of the multiplier first.
  - MUL returns product[WIDTH−1:0]; MULHU returns product[2·WIDTH−1:WIDTH].
  - All arithmetic is unsigned, modulo 2^(2·WIDTH).
- **DIVU / REMU:**
  - Restoring division with a (WIDTH+1)-bit partial remainder and a WIDTH-bit quotient, MSB of the dividend first.
  - Each iteration: rem ← {rem, a_msb}. If rem ≥ {0, b}, subtract and shift in 1; otherwise shift in 0.
- **Divide by zero:**
  - No special case and no exception.
  - The iteration naturally yields quotient = all ones and remainder = a.
  - Both results must match exactly (RISC-V semantics).
- **DONE:**
  - `ostream_val` = 1 and `ostream_result` is held stable until `ostream_val` && `ostream_rdy`, then go to IDLE.
  - `istream_rdy` = 0 throughout DONE; there is no same-cycle overlap of result drain and new accept.
- **Result register:** written only on the CALC→DONE transition. It keeps its value in IDLE, but the value is only meaningful while `ostream_val` is high.
- **Iteration counter:** width is $clog2(WIDTH)+1 bits; it never wraps during a valid operation.

## Timing
- Request accepted at edge E0 (val && rdy in the cycle before E0).
- CALC occupies the WIDTH cycles following E0.
- `ostream_val` rises after edge E0+WIDTH, i.e. in cycle WIDTH+1 counted from the accept cycle.
- **Latency:** fixed at WIDTH+1 cycles for every fn and every operand value, including zero operands and a zero divisor.
- **Minimum initiation interval:** WIDTH+2 cycles (accept, WIDTH × CALC, DONE with immediate `ostream_rdy`, then back in IDLE).
- **Backpressure:** DONE persists for any number of cycles with `ostream_rdy` = 0. Outputs must not change during that time.
- `ostream_rdy` asserted while not in DONE has no effect.
- **Reset mid-operation:**
  - Asynchronous return to IDLE; any in-flight result is discarded and `ostream_val` never asserts for it.
  - `istream_rdy` goes high in the first cycle after `rst` deasserts.
- **Simultaneous events:** `istream_val` during DONE is neither accepted nor lost; it stays pending for the producer to hold until `istream_rdy` goes high.

## Test plan
- MUL, WIDTH=32, a=7, b=6, `ostream_rdy` tied high: result 42 with `ostream_val` in cycle 33 after accept. `busy` is high for exactly 33 cycles.
- WIDTH=32, a = b = 0xFFFFFFFF: MUL → 0x00000001 and MULHU → 0xFFFFFFFE. Repeat on a WIDTH=8 instance with a = b = 0xFF: MUL → 0x01 and MULHU → 0xFE, latency 9.
- DIVU/REMU, WIDTH=32: 100/7 → 14 and 2. 0xFFFFFFFF/1 → 0xFFFFFFFF and 0. 3/10 → 0 and 3.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, with the same 33-cycle latency.
- Backpressure: hold `ostream_rdy` low for 10 cycles in DONE. `ostream_val` and the result stay stable and `istream_rdy` stays 0. Assert `ostream_rdy`: `istream_rdy` is 1 the next cycle, and a back-to-back request then completes correctly.
- Reset mid-operation: pulse `rst` asynchronously (off-edge) 10 cycles into CALC. Outputs go to their reset values immediately, `ostream_val` never asserts, and a new MUL 3×3 → 9 completes normally afterwards.

Source files
------------

// File: rtl/iter_muldiv_unit.sv
// Iterative multiply/divide execute unit: one bit per cycle, shift-add
// multiply and restoring divide, val/rdy handshake on both sides.
module iter_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             istream_val,
  output logic             istream_rdy,
  input  logic [1:0]       istream_fn,
  input  logic [WIDTH-1:0] istream_a,
  input  logic [WIDTH-1:0] istream_b,
  output logic             ostream_val,
  input  logic             ostream_rdy,
  output logic [WIDTH-1:0] ostream_result,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [1:0] FN_MUL   = 2'd0;
  localparam logic [1:0] FN_MULHU = 2'd1;
  localparam logic [1:0] FN_DIVU  = 2'd2;
  localparam logic [1:0] FN_REMU  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       fn_q, fn_d;
  // a_q: multiplicand for MUL*, dividend that shifts out MSB-first and
  // collects quotient bits in its LSB for DIV*/REM*.
  logic [WIDTH-1:0] a_q, a_d;
  // b_q: multiplier consumed LSB-first for MUL*, fixed divisor for DIV*/REM*.
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             oval_q, oval_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;

  // Single-iteration datapath values
  logic [WIDTH:0]   mul_sum;
  logic [PW-1:0]    mul_next;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;

  // One shift-add / restoring-divide step, then next-state and output decode
  always_comb begin
    state_d  = state_q;
    fn_d     = fn_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    oval_d   = oval_q;
    rdy_d    = rdy_q;
    busy_d   = busy_q;

    mul_sum  = {1'b0, prod_q[PW-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};
    mul_next = {mul_sum, prod_q[WIDTH-1:1]};

    // rem_q[WIDTH] is always zero between steps; folding it into the compare
    // keeps the test exact over the full shifted value.
    rem_sh   = {rem_q[WIDTH-1:0], a_q[WIDTH-1]};
    div_ge   = rem_q[WIDTH] | (rem_sh >= {1'b0, b_q});
    rem_next = div_ge ? (rem_sh - {1'b0, b_q}) : rem_sh;
    quo_next = {a_q[WIDTH-2:0], div_ge};

    case (state_q)
      S_IDLE: begin
        if (istream_val) begin
          fn_d    = istream_fn;
          a_d     = istream_a;
          b_d     = istream_b;
          prod_d  = '0;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_CALC;
          rdy_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_CALC: begin
        if (fn_q[1]) begin
          rem_d = rem_next;
          a_d   = quo_next;
        end else begin
          prod_d = mul_next;
          b_d    = b_q >> 1;
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          oval_d  = 1'b1;
          case (fn_q)
            FN_MUL:   result_d = mul_next[WIDTH-1:0];
            FN_MULHU: result_d = mul_next[PW-1:WIDTH];
            FN_DIVU:  result_d = quo_next;
            FN_REMU:  result_d = rem_next[WIDTH-1:0];
            default:  result_d = result_q;
          endcase
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (ostream_rdy) begin
          state_d = S_IDLE;
          oval_d  = 1'b0;
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        oval_d  = 1'b0;
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      fn_q     <= FN_MUL;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      oval_q   <= 1'b0;
      rdy_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fn_q     <= fn_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      oval_q   <= oval_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  // Ready is held low for as long as reset is asserted, and is high in the
  // first cycle after reset releases.
  assign istream_rdy    = rdy_q & ~rst;
  assign ostream_val    = oval_q;
  assign ostream_result = result_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Scoreboard bench for iter_muldiv_unit (WIDTH=32 and WIDTH=8 instances).
module tb_iter_muldiv_unit;

  localparam logic [1:0] MUL   = 2'd0;
  localparam logic [1:0] MULHU = 2'd1;
  localparam logic [1:0] DIVU  = 2'd2;
  localparam logic [1:0] REMU  = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        val32 = 1'b0;
  logic        rdy32;
  logic [1:0]  fn32 = 2'd0;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  logic        oval32;
  logic        ordy32 = 1'b1;
  logic [31:0] res32;
  logic        busy32;

  logic        val8 = 1'b0;
  logic        rdy8;
  logic [1:0]  fn8 = 2'd0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        oval8;
  logic        ordy8 = 1'b1;
  logic [7:0]  res8;
  logic        busy8;

  iter_muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst),
    .istream_val(val32), .istream_rdy(rdy32), .istream_fn(fn32),
    .istream_a(a32), .istream_b(b32),
    .ostream_val(oval32), .ostream_rdy(ordy32), .ostream_result(res32),
    .busy(busy32)
  );

  iter_muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .istream_val(val8), .istream_rdy(rdy8), .istream_fn(fn8),
    .istream_a(a8), .istream_b(b8),
    .ostream_val(oval8), .ostream_rdy(ordy8), .ostream_result(res8),
    .busy(busy8)
  );

  typedef struct {
    logic [31:0] res;
    int unsigned acc;
    string       name;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int unsigned checks = 0;
  int unsigned passed = 0;
  bit seen32 = 1'b0;
  bit seen8  = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Monitor for the 32-bit unit: latency on first valid, result on handshake
  always @(negedge clk) begin
    if (!rst && oval32 === 1'b1) begin
      if (q32.size() == 0) begin
        check("unexpected_val32", 64'(oval32), 64'd0);
      end else begin
        if (!seen32) begin
          check({q32[0].name, "_latency"}, 64'(cyc - q32[0].acc), 64'd32);
          seen32 = 1'b1;
        end
        if (ordy32) begin
          check(q32[0].name, 64'(res32), 64'(q32[0].res));
          void'(q32.pop_front());
          seen32 = 1'b0;
        end
      end
    end
  end

  // Monitor for the 8-bit unit
  always @(negedge clk) begin
    if (!rst && oval8 === 1'b1) begin
      if (q8.size() == 0) begin
        check("unexpected_val8", 64'(oval8), 64'd0);
      end else begin
        if (!seen8) begin
          check({q8[0].name, "_latency"}, 64'(cyc - q8[0].acc), 64'd8);
          seen8 = 1'b1;
        end
        if (ordy8) begin
          check(q8[0].name, 64'(res8), 64'(q8[0].res));
          void'(q8.pop_front());
          seen8 = 1'b0;
        end
      end
    end
  end

  task automatic issue(input bit is8, input logic [1:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp,
                       input string name, input bit push);
    int unsigned n;
    bit ok;
    exp_t e;
    n  = 0;
    ok = 1'b0;
    @(posedge clk); #1;
    if (is8) begin val8 = 1'b1; fn8 = fn; a8 = a[7:0]; b8 = b[7:0]; end
    else begin val32 = 1'b1; fn32 = fn; a32 = a; b32 = b; end
    while (!ok && n < 200) begin
      @(negedge clk);
      if ((is8 ? rdy8 : rdy32) === 1'b1) ok = 1'b1;
      else n++;
    end
    if (!ok) begin
      checks++;
      $display("FAIL %s_accept: istream_rdy not seen within 200 cycles", name);
      val8 = 1'b0; val32 = 1'b0;
      return;
    end
    @(posedge clk); #1;
    e.res  = exp;
    e.acc  = cyc;
    e.name = name;
    val8  = 1'b0;
    val32 = 1'b0;
    if (push) begin
      if (is8) q8.push_back(e);
      else q32.push_back(e);
    end
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q32.size() != 0 || q8.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d/%0d results outstanding, expected 0", q32.size(), q8.size());
    end
  endtask

  initial begin
    int unsigned bc;
    int unsigned n;

    repeat (3) @(negedge clk);
    check("reset_rdy32", 64'(rdy32), 64'd0);
    check("reset_val32", 64'(oval32), 64'd0);
    check("reset_res32", 64'(res32), 64'd0);
    check("reset_busy32", 64'(busy32), 64'd0);
    check("reset_rdy8", 64'(rdy8), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rdy_after_reset", 64'(rdy32), 64'd1);

    // MUL 7*6 with busy window measurement
    issue(1'b0, MUL, 32'd7, 32'd6, 32'd42, "mul_7x6", 1'b1);
    bc = 0;
    n  = 0;
    while (n < 200) begin
      @(negedge clk);
      if (busy32 !== 1'b1) break;
      bc++;
      n++;
    end
    check("busy_cycles", 64'(bc), 64'd33);

    issue(1'b0, MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_ff",   1'b1);
    issue(1'b0, MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ff", 1'b1);
    issue(1'b0, DIVU,  32'd100, 32'd7,  32'd14, "divu_100_7", 1'b1);
    issue(1'b0, REMU,  32'd100, 32'd7,  32'd2,  "remu_100_7", 1'b1);
    issue(1'b0, DIVU,  32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, "divu_max_1", 1'b1);
    issue(1'b0, REMU,  32'hFFFF_FFFF, 32'd1, 32'd0,         "remu_max_1", 1'b1);
    issue(1'b0, DIVU,  32'd3, 32'd10, 32'd0, "divu_3_10", 1'b1);
    issue(1'b0, REMU,  32'd3, 32'd10, 32'd3, "remu_3_10", 1'b1);
    issue(1'b0, DIVU,  32'd5, 32'd0, 32'hFFFF_FFFF, "divu_5_0", 1'b1);
    issue(1'b0, REMU,  32'd5, 32'd0, 32'd5,         "remu_5_0", 1'b1);

    issue(1'b1, MUL,   32'hFF, 32'hFF, 32'h01, "mul8_ff",   1'b1);
    issue(1'b1, MULHU, 32'hFF, 32'hFF, 32'hFE, "mulhu8_ff", 1'b1);
    issue(1'b1, DIVU,  32'd200, 32'd9, 32'd22, "divu8_200_9", 1'b1);
    drain();

    // Backpressure: result held in DONE for 10 cycles
    @(posedge clk); #1 ordy32 = 1'b0;
    issue(1'b0, MUL, 32'd12345, 32'd1000, 32'd12345000, "mul_bp", 1'b1);
    n = 0;
    while (oval32 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp_val_seen", 64'(oval32), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_val",  64'(oval32), 64'd1);
      check("bp_res",  64'(res32),  64'd12345000);
      check("bp_rdy",  64'(rdy32),  64'd0);
      check("bp_busy", 64'(busy32), 64'd1);
    end
    @(posedge clk); #1 ordy32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rdy_after_drain", 64'(rdy32), 64'd1);
    issue(1'b0, MULHU, 32'h0001_0000, 32'h0001_0000, 32'd1, "mulhu_b2b", 1'b1);
    drain();

    // Reset mid-operation: in-flight result must never appear
    issue(1'b0, MUL, 32'h1234, 32'h5678, 32'd0, "mul_aborted", 1'b0);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_rdy",  64'(rdy32),  64'd0);
    check("midrst_val",  64'(oval32), 64'd0);
    check("midrst_busy", 64'(busy32), 64'd0);
    check("midrst_res",  64'(res32),  64'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rdy_after_midrst", 64'(rdy32), 64'd1);
    repeat (40) @(negedge clk);
    issue(1'b0, MUL, 32'd3, 32'd3, 32'd9, "mul_3x3", 1'b1);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
